// File: rtl/rcc_hsi_div_mon.sv
// Monitor for the HSI divider clock-enable strobe: measures pulse spacing,
// decodes it back to the divider select code, locks, and flags mismatch/stall.
module rcc_hsi_div_mon #(
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 16,
  parameter int CNT_W    = 5
) (
  input  logic       i_clk,
  input  logic       rst,
  input  logic       mon_en,
  input  logic       div_en,
  input  logic [1:0] exp_sel,
  input  logic       err_clr,
  output logic [1:0] meas_sel,
  output logic       meas_vld,
  output logic       err_mismatch,
  output logic       err_timeout
);

  typedef enum logic [1:0] {IDLE, SYNC, TRACK, LOCKED} state_t;

  localparam logic [CNT_W-1:0] PCNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] PCNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PCNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [3:0]       LOCK_N    = 4'(LOCK_CNT);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] pcnt, pcnt_nxt;
  logic [1:0]       cand, cand_nxt;
  logic [3:0]       mcnt, mcnt_nxt;
  logic [1:0]       meas_sel_nxt;
  logic             meas_vld_nxt;
  logic [1:0]       code;
  logic             legal;
  logic [1:0]       trk_cand;
  logic [3:0]       trk_mcnt;
  logic             timeout_hit;
  logic             mismatch_set;

  // Period P = pcnt+1, so only pcnt values 0/1/3/7 are legal divider ratios.
  always_comb begin
    legal = 1'b1;
    code  = 2'b00;
    case (pcnt)
      CNT_W'(0): code = 2'b00;
      CNT_W'(1): code = 2'b01;
      CNT_W'(3): code = 2'b10;
      CNT_W'(7): code = 2'b11;
      default:   legal = 1'b0;
    endcase
  end

  always_comb begin
    trk_cand = cand;
    trk_mcnt = 4'd0;
    if (legal && (code == cand)) begin
      trk_mcnt = (mcnt >= LOCK_N) ? LOCK_N : mcnt + 4'd1;
    end else if (legal) begin
      trk_cand = code;
      trk_mcnt = 4'd1;
    end
  end

  assign timeout_hit  = mon_en && (state != IDLE) && !div_en && (pcnt == PCNT_LAST);
  assign mismatch_set = (state == LOCKED) && (meas_sel != exp_sel);

  // Priority: enable drop, then stall timeout, then per-state pulse handling.
  always_comb begin
    state_nxt    = state;
    pcnt_nxt     = pcnt;
    cand_nxt     = cand;
    mcnt_nxt     = mcnt;
    meas_sel_nxt = meas_sel;
    meas_vld_nxt = meas_vld;
    if (div_en) begin
      pcnt_nxt = '0;
    end else if (pcnt != PCNT_MAX) begin
      pcnt_nxt = pcnt + PCNT_ONE;
    end
    if (!mon_en) begin
      state_nxt    = IDLE;
      pcnt_nxt     = '0;
      mcnt_nxt     = 4'd0;
      meas_vld_nxt = 1'b0;
    end else if (timeout_hit) begin
      state_nxt    = SYNC;
      pcnt_nxt     = '0;
      mcnt_nxt     = 4'd0;
      meas_vld_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pcnt_nxt  = '0;
          state_nxt = SYNC;
        end
        SYNC: begin
          if (div_en) begin
            state_nxt = TRACK;
            mcnt_nxt  = 4'd0;
          end
        end
        TRACK: begin
          if (div_en) begin
            cand_nxt = trk_cand;
            mcnt_nxt = trk_mcnt;
            if (trk_mcnt == LOCK_N) begin
              state_nxt    = LOCKED;
              meas_sel_nxt = trk_cand;
              meas_vld_nxt = 1'b1;
            end
          end
        end
        LOCKED: begin
          if (div_en) begin
            cand_nxt = trk_cand;
            mcnt_nxt = trk_mcnt;
            if (!(legal && (code == meas_sel))) begin
              state_nxt    = TRACK;
              meas_vld_nxt = 1'b0;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as err_clr wins.
  always_ff @(posedge i_clk) begin
    if (rst) begin
      state        <= IDLE;
      pcnt         <= '0;
      cand         <= 2'b00;
      mcnt         <= 4'd0;
      meas_sel     <= 2'b00;
      meas_vld     <= 1'b0;
      err_mismatch <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      state        <= state_nxt;
      pcnt         <= pcnt_nxt;
      cand         <= cand_nxt;
      mcnt         <= mcnt_nxt;
      meas_sel     <= meas_sel_nxt;
      meas_vld     <= meas_vld_nxt;
      err_mismatch <= mismatch_set | (err_mismatch & ~err_clr);
      err_timeout  <= timeout_hit | (err_timeout & ~err_clr);
    end
  end

endmodule
